feature_frame_assembler: RTL and testbench



---
 rtl/feature_frame_assembler_pkg.sv | 20 ++
 rtl/feature_frame_assembler_buffer_bank.sv | 50 +++++
 rtl/feature_frame_assembler.sv | 126 ++++++++++++
 tb/tb_feature_frame_assembler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/feature_frame_assembler_pkg.sv
// ---------------------------------------------------------------------------
// feature_frame_assembler_pkg : shared types and helpers for the assembler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package feature_frame_assembler_pkg;

  localparam int c_NUM_BUFS = 2;

  typedef logic buf_sel_t;

  // Slot index width; a single-channel frame still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/feature_frame_assembler_buffer_bank.sv
// ---------------------------------------------------------------------------
// frame_buffer_bank : two frame buffers with per-slot write and buffer-select read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_buffer_bank
  import feature_frame_assembler_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = 8,
  parameter int IDX_W        = 2
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  buf_sel_t                         wr_buf,
  input  logic [IDX_W-1:0]                 wr_slot,
  input  logic [CH_WIDTH-1:0]              wr_data,
  input  buf_sel_t                         rd_sel,
  output logic [NUM_CHANNELS*CH_WIDTH-1:0] rd_data
);

  logic [NUM_CHANNELS*CH_WIDTH-1:0] bank_w [c_NUM_BUFS];

  for (genvar b = 0; b < c_NUM_BUFS; b++) begin : g_buf
    logic [NUM_CHANNELS*CH_WIDTH-1:0] mem_q;
    logic [NUM_CHANNELS*CH_WIDTH-1:0] mem_d;

    always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (wr_en && (wr_buf == buf_sel_t'(b)) && (wr_slot == IDX_W'(k))) begin
          mem_d[k*CH_WIDTH +: CH_WIDTH] = wr_data;
        end
      end
    end

    // Payload storage carries no reset; only the control flags do.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    assign bank_w[b] = mem_q;
  end

  assign rd_data = bank_w[rd_sel];

endmodule

`default_nettype wire

// File: rtl/feature_frame_assembler.sv
// ---------------------------------------------------------------------------
// feature_frame_assembler : ping-pong assembly of channel samples into frames
// Rev 1.0
// ---------------------------------------------------------------------------
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

`default_nettype none

module feature_frame_assembler
  import feature_frame_assembler_pkg::*;
#(
  parameter int NUM_CHANNELS = `TOTAL_NUM_CHANNEL,
  parameter int CH_WIDTH     = `CHANNEL_WIDTH,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CH_WIDTH-1:0]              ch_data,
  input  logic                             ch_valid,
  input  logic                             ch_last,
  output logic                             ch_ready,
  output logic [NUM_CHANNELS*CH_WIDTH-1:0] features_top,
  output logic                             fin_valid,
  input  logic                             fin_ready,
  output logic                             frame_err,
  output logic [CNT_WIDTH-1:0]             drop_count
);

  localparam int               IDX_W      = idx_width(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  logic [c_NUM_BUFS-1:0] full_q, full_d;
  buf_sel_t              wr_ptr_q, wr_ptr_d;
  buf_sel_t              rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frame_err_q, frame_err_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic w_accept;
  logic w_at_last;
  logic w_good;
  logic w_bad;
  logic w_out_hs;

  assign ch_ready  = ~full_q[wr_ptr_q];
  assign fin_valid = full_q[rd_ptr_q];
  assign frame_err  = frame_err_q;
  assign drop_count = drop_count_q;

  assign w_accept  = ch_valid & ch_ready;
  assign w_at_last = (idx_q == c_LAST_IDX);
  assign w_good    = w_accept & ch_last & w_at_last;
  // Early last and missing last at the final slot are both malformed.
  assign w_bad     = w_accept & (ch_last ^ w_at_last);
  assign w_out_hs  = fin_valid & fin_ready;

  always_comb begin
    full_d       = full_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    idx_d        = idx_q;
    frame_err_d  = w_bad;
    drop_count_d = drop_count_q;

    // A write only lands in an empty buffer and a read only drains a full
    // one, so these two updates never target the same flag.
    if (w_good) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
      idx_d            = '0;
    end else if (w_bad) begin
      idx_d = '0;
    end else if (w_accept) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (w_out_hs) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end

    if (w_bad && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      idx_q        <= '0;
      frame_err_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      full_q       <= full_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      frame_err_q  <= frame_err_d;
      drop_count_q <= drop_count_d;
    end
  end

  frame_buffer_bank #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_WIDTH     (CH_WIDTH),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (w_accept),
    .wr_buf  (wr_ptr_q),
    .wr_slot (idx_q),
    .wr_data (ch_data),
    .rd_sel  (rd_ptr_q),
    .rd_data (features_top)
  );

endmodule

`default_nettype wire

// File: tb/tb_feature_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_feature_frame_assembler : directed self-checking bench for the assembler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_feature_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ch_data;
  logic        ch_valid;
  logic        ch_last;
  logic        ch_ready;
  logic [31:0] features_top;
  logic        fin_valid;
  logic        fin_ready;
  logic        frame_err;
  logic [7:0]  drop_count;

  logic        ch_ready2;
  logic [31:0] features2;
  logic        fin_valid2;
  logic        frame_err2;
  logic [1:0]  drop_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  feature_frame_assembler #(.NUM_CHANNELS(4), .CH_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_last(ch_last), .ch_ready(ch_ready), .features_top(features_top),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .frame_err(frame_err),
    .drop_count(drop_count)
  );

  feature_frame_assembler #(.NUM_CHANNELS(4), .CH_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_last(ch_last), .ch_ready(ch_ready2), .features_top(features2),
    .fin_valid(fin_valid2), .fin_ready(fin_ready), .frame_err(frame_err2),
    .drop_count(drop_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample and hold it until the assembler accepts it.
  task automatic send(input logic [7:0] d, input logic l);
    int waited = 0;
    ch_data  = d;
    ch_last  = l;
    ch_valid = 1'b1;
    while (!ch_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ch_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    ch_data   = 8'h00;
    ch_valid  = 1'b0;
    ch_last   = 1'b0;
    fin_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    chk("rst_ch_ready",   ch_ready,   1);
    chk("rst_fin_valid",  fin_valid,  0);
    chk("rst_frame_err",  frame_err,  0);
    chk("rst_drop_count", drop_count, 0);

    // Basic frame, delivered one cycle after the last sample.
    fin_ready = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("basic_not_yet_valid", fin_valid, 0);
    send(8'h44, 1);
    chk("basic_fin_valid", fin_valid, 1);
    chk("basic_features",  features_top, 32'h44332211);
    tick();
    chk("basic_drained", fin_valid, 0);

    // Back-pressure: two frames fill both buffers, third is stalled.
    fin_ready = 1'b0;
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 1);
    chk("bp_ch_ready_low", ch_ready, 0);
    chk("bp_fin_valid",    fin_valid, 1);
    chk("bp_features_A",   features_top, 32'hA4A3A2A1);
    ch_data  = 8'hC1;
    ch_last  = 1'b0;
    ch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ready", ch_ready, 0);
      chk("bp_stable_A",    features_top, 32'hA4A3A2A1);
    end
    fin_ready = 1'b1;
    tick();
    fin_ready = 1'b0;
    chk("bp_ready_rises", ch_ready, 1);
    chk("bp_fin_valid_B", fin_valid, 1);
    chk("bp_features_B",  features_top, 32'hB4B3B2B1);
    send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0);
    chk("bp_hold_B", features_top, 32'hB4B3B2B1);
    // Completion of C and delivery of B on the same edge.
    fin_ready = 1'b1;
    send(8'hC4, 1);
    chk("simul_fin_valid", fin_valid, 1);
    chk("simul_features_C", features_top, 32'hC4C3C2C1);
    chk("simul_ch_ready",   ch_ready, 1);
    tick();
    chk("bp_all_drained", fin_valid, 0);

    // Short frame discarded, next frame intact.
    send(8'h55, 0); send(8'h66, 1);
    chk("short_frame_err",  frame_err, 1);
    chk("short_drop_count", drop_count, 1);
    chk("short_no_valid",   fin_valid, 0);
    tick();
    chk("short_err_once", frame_err, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    chk("short_next_valid",    fin_valid, 1);
    chk("short_next_features", features_top, 32'h04030201);
    tick();

    // Oversized frame: fourth sample without last is dropped.
    send(8'h71, 0); send(8'h72, 0); send(8'h73, 0); send(8'h74, 0);
    chk("long_frame_err",  frame_err, 1);
    chk("long_drop_count", drop_count, 2);
    chk("long_no_valid",   fin_valid, 0);
    send(8'h75, 0);
    chk("long_err_cleared", frame_err, 0);
    send(8'h76, 0); send(8'h77, 0); send(8'h78, 1);
    chk("long_restart_valid",    fin_valid, 1);
    chk("long_restart_features", features_top, 32'h78777675);
    tick();

    // Reset mid-frame with one complete frame also pending.
    fin_ready = 1'b0;
    send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 1);
    chk("mid_pending_valid", fin_valid, 1);
    send(8'h81, 0); send(8'h82, 0);
    rst = 1'b0;
    #2;
    chk("mid_rst_fin_valid",  fin_valid, 0);
    chk("mid_rst_frame_err",  frame_err, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_ch_ready",   ch_ready, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_post_frame_err", frame_err, 0);
    chk("mid_post_fin_valid", fin_valid, 0);
    fin_ready = 1'b1;
    send(8'h91, 0); send(8'h92, 0); send(8'h93, 0); send(8'h94, 1);
    chk("mid_next_valid",     fin_valid, 1);
    chk("mid_next_features",  features_top, 32'h94939291);
    chk("mid_next_features2", features2, 32'h94939291);
    chk("mid_next_valid2",    fin_valid2, 1);
    tick();

    // Saturation of the narrow counter.
    for (int i = 0; i < 5; i++) begin
      send(8'hE0 + 8'(i), 1);
      if (i == 2) chk("sat_at_three", drop_count2, 3);
    end
    chk("sat_wide_count",   drop_count, 5);
    chk("sat_narrow_count", drop_count2, 3);
    chk("sat_err_pulse2",   frame_err2, 1);
    chk("sat_ch_ready2",    ch_ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
